sparse_mac_pe: RTL

- Parametrised sparse processing element for the compressed-CNN datapath.
- Latches one compressed input-activation (IA) vector: nonzero values plus channel indices.
- Consumes a stream of compressed weight entries, one per cycle, each carrying value, input-channel index and output-channel index.
- Matches each weight against the IA vector by channel index, multiply-accumulates into per-output-channel accumulators, and presents saturated output activations (OA) with the start/finish handshake the PE array controller already drives.

---
 rtl/sparse_mac_pe.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/sparse_mac_pe.sv
// Sparse MAC PE: matches streamed compressed weights against a latched IA vector and accumulates per output channel.
// Latency: last weight transfer at cycle t -> accumulators final at t+2 -> o_finish and o_oa valid at t+3.
// Backpressure: o_w_ready is high only in PROC; no stall inside the 2-stage pipe. Optional ReLU: SPARSE_MAC_PE_RELU_EN.
module sparse_mac_pe #(
  parameter int IA_NZ     = 32,
  parameter int K_OUT     = 16,
  parameter int DATA_W    = 8,
  parameter int ACC_W     = 20,
  parameter int C_IDX_W   = 5,
  parameter int K_IDX_W   = 4,
  parameter int OUT_SHIFT = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_start,
  input  logic [IA_NZ*DATA_W-1:0]     i_ia_data,
  input  logic [IA_NZ*C_IDX_W-1:0]    i_ia_c_idx,
  input  logic [$clog2(IA_NZ):0]      i_ia_len,
  input  logic                        i_w_valid,
  output logic                        o_w_ready,
  input  logic signed [DATA_W-1:0]    i_w_data,
  input  logic [C_IDX_W-1:0]          i_w_c_idx,
  input  logic [K_IDX_W-1:0]          i_w_k_idx,
  input  logic                        i_w_last,
  output logic                        o_busy,
  output logic                        o_finish,
  output logic [K_OUT*DATA_W-1:0]     o_oa
);

  localparam int LEN_W = $clog2(IA_NZ) + 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_PROC   = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;

  // Saturation bounds; the accumulator sum carries one guard bit
  localparam logic signed [ACC_W:0]   ACC_MAX = {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W:0]   ACC_MIN = {2'b11, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] OA_MAX  = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OA_MIN  = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic [2:0]                 state;
  logic                       drain_cnt;
  logic                       w_xfer;

  logic [IA_NZ*DATA_W-1:0]    ia_data_q;
  logic [IA_NZ*C_IDX_W-1:0]   ia_c_q;
  logic [LEN_W-1:0]           ia_len_q;

  logic                       hit;
  logic signed [DATA_W-1:0]   sel_a;
  logic                       k_ok;

  logic                       s1_vld;
  logic signed [DATA_W-1:0]   s1_a;
  logic signed [DATA_W-1:0]   s1_w;
  logic [K_IDX_W-1:0]         s1_k;

  logic signed [ACC_W-1:0]    acc [K_OUT];
  logic signed [ACC_W-1:0]    acc_rd;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W:0]      prod_ext;
  logic signed [ACC_W:0]      sum;
  logic signed [ACC_W-1:0]    acc_nxt;

  // Clamp the pre-shifted accumulator to the OA range, optionally zeroing negatives
  function automatic logic [DATA_W-1:0] oa_of(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] sh;
    logic signed [ACC_W-1:0] cl;
    sh = a >>> OUT_SHIFT;
    if (sh > OA_MAX)      cl = OA_MAX;
    else if (sh < OA_MIN) cl = OA_MIN;
    else                  cl = sh;
`ifdef SPARSE_MAC_PE_RELU_EN
    if (cl[ACC_W-1]) cl = '0;
`endif
    return cl[DATA_W-1:0];
  endfunction

  assign w_xfer    = i_w_valid && (state == S_PROC);
  assign o_w_ready = (state == S_PROC);
  assign o_busy    = (state == S_LOAD) || (state == S_PROC) || (state == S_DRAIN);
  assign o_finish  = (state == S_FINISH);

  // Job control FSM; DRAIN lasts exactly two cycles to flush both pipe stages
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= S_IDLE;
      drain_cnt <= 1'b0;
    end else begin
      case (state)
        S_IDLE:   if (i_start) state <= S_LOAD;
        S_LOAD:   state <= S_PROC;
        S_PROC: begin
          if (w_xfer && i_w_last) begin
            state     <= S_DRAIN;
            drain_cnt <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (drain_cnt) state <= S_FINISH;
          drain_cnt <= 1'b1;
        end
        S_FINISH: if (!i_start) state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  // Latch the IA vector once per job; an over-long length saturates at IA_NZ
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ia_data_q <= '0;
      ia_c_q    <= '0;
      ia_len_q  <= '0;
    end else if (state == S_LOAD) begin
      ia_data_q <= i_ia_data;
      ia_c_q    <= i_ia_c_idx;
      ia_len_q  <= (i_ia_len > LEN_W'(IA_NZ)) ? LEN_W'(IA_NZ) : i_ia_len;
    end
  end

  // Parallel channel match; scanning downwards lets the lowest index win
  always_comb begin
    hit   = 1'b0;
    sel_a = '0;
    for (int j = IA_NZ - 1; j >= 0; j--) begin
      if ((LEN_W'(j) < ia_len_q) && (ia_c_q[j*C_IDX_W +: C_IDX_W] == i_w_c_idx)) begin
        hit   = 1'b1;
        sel_a = ia_data_q[j*DATA_W +: DATA_W];
      end
    end
  end

  assign k_ok = {1'b0, i_w_k_idx} < (K_IDX_W+1)'(K_OUT);

  // Stage 1: register matched operand pair; misses and out-of-range k become bubbles
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_vld <= 1'b0;
      s1_a   <= '0;
      s1_w   <= '0;
      s1_k   <= '0;
    end else begin
      s1_vld <= w_xfer && hit && k_ok;
      s1_a   <= sel_a;
      s1_w   <= i_w_data;
      s1_k   <= i_w_k_idx;
    end
  end

  // Stage 2 read side: select the target accumulator and form the saturated sum
  always_comb begin
    acc_rd = '0;
    for (int k = 0; k < K_OUT; k++) begin
      if (s1_k == K_IDX_W'(k)) acc_rd = acc[k];
    end
  end

  assign prod     = s1_a * s1_w;
  assign prod_ext = (ACC_W+1)'(prod);
  assign sum      = $signed({acc_rd[ACC_W-1], acc_rd}) + prod_ext;

  // Clamp the guarded sum back into accumulator range
  always_comb begin
    acc_nxt = sum[ACC_W-1:0];
    if (sum > ACC_MAX)      acc_nxt = ACC_MAX[ACC_W-1:0];
    else if (sum < ACC_MIN) acc_nxt = ACC_MIN[ACC_W-1:0];
  end

  // Stage 2 write side: single-cycle read-modify-write, so back-to-back hits on one k chain correctly
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < K_OUT; k++) acc[k] <= '0;
    end else if (state == S_LOAD) begin
      for (int k = 0; k < K_OUT; k++) acc[k] <= '0;
    end else if (s1_vld) begin
      for (int k = 0; k < K_OUT; k++) begin
        if (s1_k == K_IDX_W'(k)) acc[k] <= acc_nxt;
      end
    end
  end

  // Output register tracks acc every cycle; cleared alongside acc on LOAD so it reads 0 right after
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_oa <= '0;
    end else if (state == S_LOAD) begin
      o_oa <= '0;
    end else begin
      for (int k = 0; k < K_OUT; k++) o_oa[k*DATA_W +: DATA_W] <= oa_of(acc[k]);
    end
  end

endmodule
